lcd_write_arbiter: RTL

Shares the single SPI LCD serialiser (9-bit word: bit 8 = D/C, bits 7:0 = payload; en_write/wr_done handshake) between three requesters: init sequencer (req 0), picture/row renderer (req 1), auxiliary overlay/text writer (req 2). Issues one word at a time, returns per-requester completion pulses, enforces init-first ordering, and supports locked bursts (e.g. set-window + pixel run) that are not interleaved.

---
 rtl/lcd_write_arbiter_if.sv | 28 ++
 rtl/lcd_write_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_arbiter_if.sv
// Bus between the LCD write arbiter and its environment: three requesters
// plus the shared SPI serialiser handshake. The arbiter uses the slave
// modport; requesters and serialiser together sit on the master side.
interface lcd_write_arbiter_if #(
  parameter int DATA_W = 9
);
  logic                  init_done;
  logic [2:0]            req;
  logic [2:0]            lock;
  logic [3*DATA_W-1:0]   req_data;
  logic [2:0]            grant;
  logic [2:0]            done;
  logic                  wr_en;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_done;
  logic                  busy;
  logic                  timeout_err;

  modport master (
    output init_done, req, lock, req_data, wr_done,
    input  grant, done, wr_en, wr_data, busy, timeout_err
  );

  modport slave (
    input  init_done, req, lock, req_data, wr_done,
    output grant, done, wr_en, wr_data, busy, timeout_err
  );
endinterface

// File: rtl/lcd_write_arbiter.sv
// Arbitrates the single SPI LCD serialiser between the init sequencer (0),
// the row renderer (1) and the overlay writer (2). One word per grant,
// init-first ordering, round robin between 1 and 2, locked bursts kept.
// Optional macro LCD_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYC
// clocks and a sticky timeout_err flag; without it timeout_err is tied 0.
//
// state   | meaning
// ARB     | pick next owner, grant low
// ISSUE   | wr_en pulse to serialiser
// WAIT    | word shifting out, waiting for wr_done
// RELEASE | done pulse to owner, round-robin pointer update
module lcd_write_arbiter #(
  parameter int DATA_W      = 9,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic              sys_clk_50MHz,
  input logic              sys_rst,
  lcd_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [2:0]          grant_q, grant_n;
  logic [2:0]          done_q, done_n;
  logic                wr_en_q, wr_en_n;
  logic [DATA_W-1:0]   wr_data_q, wr_data_n;
  logic                busy_q, busy_n;
  logic [1:0]          rr_last, rr_last_n;
  logic [2:0]          owner_oh, owner_oh_n;
  logic [2:0]          sel_oh;
  logic [DATA_W-1:0]   sel_data;

  // Watchdog needs at least two WAIT cycles to be meaningful.
  generate
    if (TIMEOUT_CYC < 2) begin : g_tmo_param_check
      $error("lcd_write_arbiter: TIMEOUT_CYC must be >= 2");
    end
  endgenerate

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0]    tmo_cnt, tmo_cnt_n;
  logic                tmo_err_q, tmo_err_n;
`endif

  // Owner selection: a locked owner that still requests keeps the bus,
  // otherwise init first, then 1/2 (only after init) with round robin.
  always_comb begin
    sel_oh = 3'b000;
    if (|(owner_oh & bus.lock & bus.req)) begin
      sel_oh = owner_oh;
    end else if (bus.req[0]) begin
      sel_oh = 3'b001;
    end else if (bus.init_done) begin
      if (bus.req[1] && bus.req[2]) begin
        sel_oh = (rr_last == 2'd1) ? 3'b100 : 3'b010;
      end else if (bus.req[1]) begin
        sel_oh = 3'b010;
      end else if (bus.req[2]) begin
        sel_oh = 3'b100;
      end
    end
  end

  // Word of the selected requester.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (sel_oh[i]) begin
        sel_data = bus.req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_n    = state;
    grant_n    = grant_q;
    done_n     = 3'b000;
    wr_en_n    = 1'b0;
    wr_data_n  = wr_data_q;
    rr_last_n  = rr_last;
    owner_oh_n = owner_oh;
`ifdef LCD_ARB_TIMEOUT_EN
    tmo_cnt_n  = tmo_cnt;
    tmo_err_n  = tmo_err_q;
`endif
    case (state)
      ST_ARB: begin
        grant_n = sel_oh;
        if (|sel_oh) begin
          state_n    = ST_ISSUE;
          wr_en_n    = 1'b1;
          wr_data_n  = sel_data;
          owner_oh_n = sel_oh;
        end
      end
      ST_ISSUE: begin
        state_n = ST_WAIT;
`ifdef LCD_ARB_TIMEOUT_EN
        tmo_cnt_n = '0;
`endif
      end
      ST_WAIT: begin
        if (bus.wr_done) begin
          state_n = ST_RELEASE;
          done_n  = grant_q;
        end
`ifdef LCD_ARB_TIMEOUT_EN
        else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_n   = ST_RELEASE;
          done_n    = grant_q;
          tmo_err_n = 1'b1;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
`endif
      end
      ST_RELEASE: begin
        state_n = ST_ARB;
        grant_n = 3'b000;
        if (grant_q[1]) rr_last_n = 2'd1;
        if (grant_q[2]) rr_last_n = 2'd2;
      end
      default: begin
        state_n = ST_ARB;
        grant_n = 3'b000;
      end
    endcase
    busy_n = (state_n != ST_ARB);
  end

  // State and output registers.
  always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= ST_ARB;
      grant_q   <= 3'b000;
      done_q    <= 3'b000;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      rr_last   <= 2'd2;
      owner_oh  <= 3'b000;
    end else begin
      state     <= state_n;
      grant_q   <= grant_n;
      done_q    <= done_n;
      wr_en_q   <= wr_en_n;
      wr_data_q <= wr_data_n;
      busy_q    <= busy_n;
      rr_last   <= rr_last_n;
      owner_oh  <= owner_oh_n;
    end
  end

`ifdef LCD_ARB_TIMEOUT_EN
  // WAIT watchdog counter and sticky error flag.
  always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
    if (sys_rst) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt   <= tmo_cnt_n;
      tmo_err_q <= tmo_err_n;
    end
  end

  assign bus.timeout_err = tmo_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;

endmodule
